// File: rtl/img_line_feeder.sv
// Frame-buffer to filter-core line feeder: primes a few lines, then sends one line per
// core interrupt and finishes with zero pad lines, all through a 2-entry read skid buffer.
module img_line_feeder #(
   parameter int unsigned LINE_WIDTH  = 512,
   parameter int unsigned NUM_LINES   = 512,
   parameter int unsigned PRIME_LINES = 4,
   parameter int unsigned PAD_LINES   = 2,
   parameter int unsigned ADDR_W      = $clog2(LINE_WIDTH*NUM_LINES),
   parameter int unsigned CRED_W      = 3
) (
   input  logic              axi_clk,
   input  logic              axi_rst,
   input  logic              i_start,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [7:0]        i_rd_data,
   output logic [7:0]        o_data,
   output logic              o_data_valid,
   input  logic              i_data_ready,
   input  logic              i_intr,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned PIX_W  = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int unsigned LIN_W  = $clog2(NUM_LINES + 1);
   localparam int unsigned PADL_W = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(LINE_WIDTH*NUM_LINES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_WAIT,
      S_LINE,
      S_PAD_WAIT,
      S_PAD,
      S_DONE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr;
   logic [PIX_W-1:0]    pix;
   logic [LIN_W-1:0]    lines;
   logic [PADL_W-1:0]   pad_lines;
   logic [CRED_W-1:0]   cred;
   logic                intr_q;
   logic                pend;
   logic                tail;
   logic [7:0]          sk [2];
   logic [1:0]          sk_cnt;

   logic                rise;
   logic                pop;
   logic                out_free;
   logic                pix_last;
   logic                zin;
   logic                land;
   logic [7:0]          land_data;
   logic                issue;
   logic                take;
   logic                last_out;
   logic                cred_hold;
   logic [7:0]          od_n;
   logic                ov_n;
   logic [7:0]          s_n [2];
   logic [1:0]          c_n;

   always_comb begin
      rise      = i_intr & ~intr_q;
      pop       = o_data_valid & i_data_ready;
      out_free  = ~o_data_valid | i_data_ready;
      pix_last  = (pix == PIX_W'(LINE_WIDTH - 1));
      // Pad zeros enter only once every RAM read has landed, so they queue behind image data.
      zin       = (state == S_PAD) && !tail && !pend && !o_rd_en && (out_free || sk_cnt != 2'd2);
      land      = pend | zin;
      land_data = pend ? i_rd_data : 8'h00;
      take      = ((state == S_WAIT) || (state == S_PAD_WAIT)) && (cred != '0);
      last_out  = (state == S_PAD) && tail && pop && (sk_cnt == 2'd0);
      cred_hold = (state == S_IDLE) || (state == S_PRIME) || (state == S_DONE);
   end

   always_comb begin
      od_n   = o_data;
      ov_n   = o_data_valid;
      s_n[0] = sk[0];
      s_n[1] = sk[1];
      c_n    = sk_cnt;
      if (out_free) begin
         ov_n = 1'b0;
         if (sk_cnt != 2'd0) begin
            od_n   = sk[0];
            ov_n   = 1'b1;
            s_n[0] = sk[1];
            c_n    = sk_cnt - 2'd1;
         end else if (land) begin
            od_n = land_data;
            ov_n = 1'b1;
         end
      end
      if (land && !(out_free && sk_cnt == 2'd0)) begin
         if (c_n == 2'd0) s_n[0] = land_data;
         else             s_n[1] = land_data;
         c_n = c_n + 2'd1;
      end
   end

   // A new read is safe if the skid can still hold it plus the read already on the bus,
   // even when the output register stays stalled.
   always_comb begin
      issue = ((state == S_PRIME) || (state == S_LINE)) &&
              ((c_n == 2'd0) || ((c_n == 2'd1) && !o_rd_en));
   end

   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         state        <= S_IDLE;
         addr         <= '0;
         pix          <= '0;
         lines        <= '0;
         pad_lines    <= '0;
         cred         <= '0;
         intr_q       <= 1'b0;
         pend         <= 1'b0;
         tail         <= 1'b0;
         sk[0]        <= '0;
         sk[1]        <= '0;
         sk_cnt       <= '0;
         o_rd_en      <= 1'b0;
         o_rd_addr    <= '0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         intr_q       <= i_intr;
         pend         <= o_rd_en;
         o_data       <= od_n;
         o_data_valid <= ov_n;
         sk[0]        <= s_n[0];
         sk[1]        <= s_n[1];
         sk_cnt       <= c_n;
         o_rd_en      <= issue;
         o_done       <= 1'b0;

         if (issue) begin
            o_rd_addr <= addr;
            if (addr != ADDR_MAX) addr <= addr + ADDR_W'(1);
            pix <= pix_last ? '0 : pix + PIX_W'(1);
            if (pix_last) lines <= lines + LIN_W'(1);
         end

         if (cred_hold) begin
            cred <= '0;
         end else if (rise && !take) begin
            if (cred != '1) cred <= cred + CRED_W'(1);
         end else if (take && !rise) begin
            cred <= cred - CRED_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (i_start) begin
                  addr      <= '0;
                  pix       <= '0;
                  lines     <= '0;
                  pad_lines <= '0;
                  tail      <= 1'b0;
                  o_busy    <= 1'b1;
                  state     <= S_PRIME;
               end
            end
            S_PRIME: begin
               if (issue && pix_last && lines == LIN_W'(PRIME_LINES - 1))
                  state <= (lines == LIN_W'(NUM_LINES - 1)) ? S_PAD_WAIT : S_WAIT;
            end
            S_WAIT: begin
               if (take) state <= S_LINE;
            end
            S_LINE: begin
               if (issue && pix_last)
                  state <= (lines == LIN_W'(NUM_LINES - 1)) ? S_PAD_WAIT : S_WAIT;
            end
            S_PAD_WAIT: begin
               if (take) state <= S_PAD;
            end
            S_PAD: begin
               if (zin) begin
                  pix <= pix_last ? '0 : pix + PIX_W'(1);
                  if (pix_last) begin
                     pad_lines <= pad_lines + PADL_W'(1);
                     if (pad_lines == PADL_W'(PAD_LINES - 1)) tail  <= 1'b1;
                     else                                     state <= S_PAD_WAIT;
                  end
               end
               if (last_out) begin
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_img_line_feeder.sv
// Directed bench for img_line_feeder: scoreboard of expected pixels popped on each transfer,
// with credit, backpressure, restart and reset scenarios.
module tb_img_line_feeder;

   localparam int unsigned LW  = 8;
   localparam int unsigned NL  = 6;
   localparam int unsigned PL  = 4;
   localparam int unsigned PDL = 2;
   localparam int unsigned AW  = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic          ready;
   logic          intr = 1'b0;
   logic          rnd_mode = 1'b0;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic [7:0]    rd_data;
   logic [7:0]    o_data;
   logic          o_data_valid;
   logic          o_busy;
   logic          o_done;

   logic [7:0]    exp_q [$];
   int unsigned   vectors = 0;
   int unsigned   errs = 0;
   int unsigned   xfer_cnt = 0;
   int unsigned   done_cnt = 0;
   logic          prev_stall = 1'b0;
   logic [7:0]    prev_data = '0;
   logic          last_prev = 1'b0;

   img_line_feeder #(
      .LINE_WIDTH (LW),
      .NUM_LINES  (NL),
      .PRIME_LINES(PL),
      .PAD_LINES  (PDL),
      .ADDR_W     (AW),
      .CRED_W     (3)
   ) dut (
      .axi_clk     (clk),
      .axi_rst     (rst_n),
      .i_start     (i_start),
      .o_rd_en     (o_rd_en),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (rd_data),
      .o_data      (o_data),
      .o_data_valid(o_data_valid),
      .i_data_ready(ready),
      .i_intr      (intr),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   initial forever #5 clk = ~clk;

   // Frame buffer holding data[a] = a, one-cycle read latency.
   always @(posedge clk) if (o_rd_en) rd_data <= 8'(o_rd_addr);

   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         last_prev  = 1'b0;
      end else begin
         if (o_done || last_prev) chk("done_after_last_xfer", 32'(o_done), 32'(last_prev));
         if (o_done) chk("busy_low_at_done", 32'(o_busy), 32'd0);
         if (prev_stall) begin
            chk("stall_valid_held", 32'(o_data_valid), 32'd1);
            chk("stall_data_held", 32'(o_data), 32'(prev_data));
         end
         if (o_rd_en) chk("addr_in_range", 32'(o_rd_addr <= AW'(LW*NL - 1)), 32'd1);
         last_prev = 1'b0;
         if (o_data_valid && ready) begin
            chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("pixel", 32'(o_data), 32'(exp_q.pop_front()));
               last_prev = (exp_q.size() == 0);
            end
            xfer_cnt++;
         end
         if (o_done) done_cnt++;
         prev_stall = o_data_valid && !ready;
         prev_data  = o_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_intr();
      tick();
      intr = 1'b1;
      tick();
      intr = 1'b0;
   endtask

   task automatic start_frame();
      for (int i = 0; i < LW*NL; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < LW*PDL; i++) exp_q.push_back(8'h00);
      xfer_cnt = 0;
      done_cnt = 0;
      tick();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_xfers(input string tag, input int unsigned target);
      int unsigned n = 0;
      while (xfer_cnt < target && n < 4000) begin
         tick();
         n++;
      end
      chk(tag, 32'(xfer_cnt >= target), 32'd1);
   endtask

   task automatic wait_done();
      int unsigned n = 0;
      while (done_cnt == 0 && n < 4000) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done_cnt), 32'd1);
   endtask

   task automatic check_latency();
      chk("lat_busy_n", 32'(o_busy), 32'd1);
      chk("lat_rden_n", 32'(o_rd_en), 32'd0);
      tick();
      chk("lat_rden_n1", 32'(o_rd_en), 32'd1);
      chk("lat_addr_n1", 32'(o_rd_addr), 32'd0);
      tick();
      chk("lat_valid_n2", 32'(o_data_valid), 32'd0);
      tick();
      chk("lat_valid_n3", 32'(o_data_valid), 32'd1);
      chk("lat_data_n3", 32'(o_data), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
      chk({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
      chk({tag, "_data"}, 32'(o_data), 32'd0);
      chk({tag, "_valid"}, 32'(o_data_valid), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
   endtask

   task automatic run_lines(input bit extra_starts);
      if (extra_starts) begin
         wait_xfers("prime_part", 20);
         tick();
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
      end
      wait_xfers("prime_done", 32);
      if (extra_starts) begin
         tick();
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         pulse_intr();
         wait_xfers("line_done", 32'(40 + 8*k));
      end
      wait_done();
      chk("frame_len", 32'(xfer_cnt), 32'd64);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int unsigned n;

      #2;
      check_idle_outputs("reset0");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_idle_outputs("idle");

      // Basic frame with latency checks, ready held high.
      start_frame();
      check_latency();
      run_lines(1'b0);
      repeat (5) tick();
      chk("basic_one_done", 32'(done_cnt), 32'd1);

      // Random backpressure.
      rnd_mode = 1'b1;
      start_frame();
      run_lines(1'b0);
      rnd_mode = 1'b0;
      repeat (5) tick();

      // Credit during priming is discarded; two later rises buy exactly two lines.
      start_frame();
      wait_xfers("cr_prime_part", 10);
      pulse_intr();
      wait_xfers("cr_prime_done", 32);
      pulse_intr();
      repeat (2) tick();
      pulse_intr();
      wait_xfers("cr_two_lines", 48);
      repeat (40) tick();
      chk("cr_stall_count", 32'(xfer_cnt), 32'd48);
      chk("cr_stall_busy", 32'(o_busy), 32'd1);
      pulse_intr();
      wait_xfers("cr_pad1", 56);
      pulse_intr();
      wait_done();
      chk("cr_frame_len", 32'(xfer_cnt), 32'd64);
      repeat (5) tick();

      // Rise coinciding with a line start while one credit is banked.
      start_frame();
      wait_xfers("same_prime", 32);
      pulse_intr();
      wait_xfers("same_line4_start", 33);
      pulse_intr();
      n = 0;
      while (!(o_rd_en && o_rd_addr == AW'(39)) && n < 200) begin
         tick();
         n++;
      end
      chk("same_addr39_seen", 32'(o_rd_en && o_rd_addr == AW'(39)), 32'd1);
      intr = 1'b1;
      tick();
      intr = 1'b0;
      wait_xfers("same_through_pad1", 56);
      repeat (40) tick();
      chk("same_stall_count", 32'(xfer_cnt), 32'd56);
      pulse_intr();
      wait_done();
      chk("same_frame_len", 32'(xfer_cnt), 32'd64);
      repeat (5) tick();

      // Start pulses while busy are ignored.
      start_frame();
      run_lines(1'b1);
      repeat (30) tick();
      chk("extra_one_done", 32'(done_cnt), 32'd1);
      chk("extra_no_restart", 32'(o_busy), 32'd0);
      chk("extra_no_reads", 32'(o_rd_en), 32'd0);

      // Reset during image line 5, then a fresh frame.
      start_frame();
      wait_xfers("rst_prime", 32);
      pulse_intr();
      wait_xfers("rst_line4", 40);
      pulse_intr();
      wait_xfers("rst_mid_line5", 43);
      tick();
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_async");
      exp_q.delete();
      tick();
      tick();
      check_idle_outputs("rst_held");
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_stays_idle", 32'(o_busy), 32'd0);
      start_frame();
      check_latency();
      run_lines(1'b0);
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
